// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, DBIT data bits LSB first, one stop bit.
// Holds the last good byte for the consumer and flags lost bytes.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd_en,
  output logic [DBIT-1:0] dout,
  output logic            data_valid,
  output logic            rx_done,
  output logic            frame_err,
  output logic            overrun,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [3:0]      s, s_n;
  logic [2:0]      n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            rx_m, rx_s;
  logic            done_set, ferr_set;

  assign state_dbg = state;

  // rx is asynchronous to clock; both flops reset to the idle line level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s;
    n_n      = n;
    b_n      = b;
    done_set = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        // mid-start-bit check: a line back high by now was only a glitch
        if (s_tick) begin
          if (s == 4'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == 4'd15) begin
            s_n = '0;
            b_n = {rx_s, b[DBIT-1:1]};
            if (n == 3'(DBIT - 1)) state_n = STOP;
            else                   n_n     = n + 3'd1;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == 4'(SB_TICK - 1)) begin
            state_n  = IDLE;
            done_set = rx_s;
            ferr_set = !rx_s;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake: a byte is consumed on any edge where data_valid && rd_en.
  // A new byte landing on that same edge replaces it and stays valid;
  // a new byte landing while the old one is unread and not consumed sets overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      data_valid <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_done   <= done_set;
      frame_err <= ferr_set;
      if (done_set) dout <= b;
      if (done_set)                 data_valid <= 1'b1;
      else if (rd_en && data_valid) data_valid <= 1'b0;
      if (done_set && data_valid && !rd_en) overrun <= 1'b1;
      else if (rd_en)                       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are aligned to the bench's own s_tick
// phase so every sample edge (and the stop-bit result edge) is known exactly.
module tb_uart_rx;

  logic       clock;
  logic       reset_n;
  logic       rx;
  logic       s_tick;
  logic       rd_en;
  logic [7:0] dout;
  logic       data_valid;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int done_cyc = 0;
  int ferr_cyc = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .s_tick     (s_tick),
    .rd_en      (rd_en),
    .dout       (dout),
    .data_valid (data_valid),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: inputs set after this returns are sampled on posedge cyc_cnt
  task automatic cyc();
    @(negedge clock);
    cyc_cnt++;
    s_tick = (cyc_cnt % 16 == 0);
  endtask

  // scoreboard: every rx_done pulse pops the next expected byte
  always @(negedge clock) begin
    if (rx_done) begin
      done_cyc++;
      if (exp_q.size() == 0) check("sb_extra_done", 32'd1, 32'd0);
      else check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
    end
    if (frame_err) ferr_cyc++;
  end

  // 8N1 frame, start edge on a tick-aligned edge c: START resolves on edge c+128,
  // data bit k is sampled on c+384+256k, the stop bit on c+2432.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input bit rd_at_done, input int rst_at);
    int   bitn;
    logic lv;
    if (stop_ok && rst_at < 0) exp_q.push_back(d);
    while (cyc_cnt % 16 != 0) cyc();
    for (int idx = 0; idx < 2816; idx++) begin
      bitn = idx / 256;
      if (bitn == 0)      lv = 1'b0;
      else if (bitn <= 8) lv = d[bitn-1];
      else if (bitn == 9) lv = stop_ok ? 1'b1 : (idx < 2304 + 160 ? 1'b0 : 1'b1);
      else                lv = 1'b1;
      rx    = lv;
      rd_en = rd_at_done && (idx == 2432);
      if (rst_at >= 0) begin
        reset_n = !(idx >= rst_at && idx < rst_at + 10);
        if (idx == rst_at + 5) begin
          check("rst_dout", 32'(dout), 32'h0);
          check("rst_valid", 32'(data_valid), 32'h0);
          check("rst_overrun", 32'(overrun), 32'h0);
          check("rst_state", 32'(state_dbg), 32'h0);
        end
      end else begin
        if (idx == 2432) check("done_early", 32'(rx_done | frame_err), 32'h0);
        if (idx == 2433) begin
          check("done_latency", 32'(rx_done), 32'(stop_ok));
          check("ferr_latency", 32'(frame_err), 32'(!stop_ok));
        end
      end
      cyc();
    end
    rd_en   = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    int d0, f0;
    reset_n = 1'b0;
    rx      = 1'b1;
    s_tick  = 1'b0;
    rd_en   = 1'b0;
    repeat (5) cyc();
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_done", 32'(rx_done), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);
    reset_n = 1'b1;
    repeat (20) cyc();

    // good frame 0x5A
    d0 = done_cyc; f0 = ferr_cyc;
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    check("5a_done_cnt", 32'(done_cyc - d0), 32'd1);
    check("5a_ferr_cnt", 32'(ferr_cyc - f0), 32'd0);
    check("5a_dout", 32'(dout), 32'h5A);
    check("5a_valid", 32'(data_valid), 32'h1);
    check("5a_overrun", 32'(overrun), 32'h0);

    // 64-clock low glitch
    d0 = done_cyc; f0 = ferr_cyc;
    while (cyc_cnt % 16 != 0) cyc();
    rx = 1'b0;
    repeat (64) cyc();
    rx = 1'b1;
    repeat (300) cyc();
    check("glitch_done_cnt", 32'(done_cyc - d0), 32'd0);
    check("glitch_ferr_cnt", 32'(ferr_cyc - f0), 32'd0);
    check("glitch_state", 32'(state_dbg), 32'h0);
    check("glitch_dout", 32'(dout), 32'h5A);

    // 0xC3 with stop bit low
    d0 = done_cyc; f0 = ferr_cyc;
    send_frame(8'hC3, 1'b0, 1'b0, -1);
    check("c3_ferr_cnt", 32'(ferr_cyc - f0), 32'd1);
    check("c3_done_cnt", 32'(done_cyc - d0), 32'd0);
    check("c3_dout", 32'(dout), 32'h5A);
    check("c3_valid", 32'(data_valid), 32'h1);
    check("c3_state", 32'(state_dbg), 32'h0);
    pop();
    check("pop_valid", 32'(data_valid), 32'h0);
    check("pop_dout", 32'(dout), 32'h5A);
    pop();
    check("pop_idle_valid", 32'(data_valid), 32'h0);

    // 0x11 then 0x22 unread -> overrun
    send_frame(8'h11, 1'b1, 1'b0, -1);
    check("11_overrun", 32'(overrun), 32'h0);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    check("22_dout", 32'(dout), 32'h22);
    check("22_overrun", 32'(overrun), 32'h1);
    check("22_valid", 32'(data_valid), 32'h1);
    pop();
    check("ovr_pop_valid", 32'(data_valid), 32'h0);
    check("ovr_pop_overrun", 32'(overrun), 32'h0);

    // 0x44 left unread, then 0x33 with rd_en on its completion edge
    send_frame(8'h44, 1'b1, 1'b0, -1);
    send_frame(8'h33, 1'b1, 1'b1, -1);
    check("33_valid", 32'(data_valid), 32'h1);
    check("33_dout", 32'(dout), 32'h33);
    check("33_overrun", 32'(overrun), 32'h0);
    pop();
    check("33_pop_valid", 32'(data_valid), 32'h0);

    // reset during data bit 4 of 0xFF, then 0x01
    d0 = done_cyc; f0 = ferr_cyc;
    send_frame(8'hFF, 1'b1, 1'b0, 1400);
    check("abort_done_cnt", 32'(done_cyc - d0), 32'd0);
    check("abort_ferr_cnt", 32'(ferr_cyc - f0), 32'd0);
    check("abort_dout", 32'(dout), 32'h0);
    check("abort_valid", 32'(data_valid), 32'h0);
    check("abort_state", 32'(state_dbg), 32'h0);
    send_frame(8'h01, 1'b1, 1'b0, -1);
    check("01_done_cnt", 32'(done_cyc - d0), 32'd1);
    check("01_dout", 32'(dout), 32'h01);
    check("01_valid", 32'(data_valid), 32'h1);
    check("01_overrun", 32'(overrun), 32'h0);

    repeat (10) cyc();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
